// File: rtl/jbi_jbus_pkt_sched.sv
// Outbound JBus packet scheduler: picks one of PIO / DMA-return / int-ack sources,
// requests the bus and sequences the granted packet. Define JBI_SCHED_RR_EN for round-robin selection.
module jbi_jbus_pkt_sched #(
  parameter int CYC_W = 4
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [2:0]         src_req,
  input  logic [3*CYC_W-1:0] src_ncyc,
  input  logic [2:0]         src_fc_ok,
  input  logic               grant,
  input  logic               multiple_ok,
  output logic               int_req,
  output logic               multiple_in_progress,
  output logic               stream_break_point,
  output logic               have_trans_waiting,
  output logic               piorqq_req,
  output logic               int_requestor_piorqq,
  output logic               drv_valid,
  output logic [1:0]         drv_src,
  output logic [CYC_W-1:0]   drv_cyc,
  output logic               drv_last,
  output logic [2:0]         src_pop
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  localparam logic [CYC_W-1:0] ONE = CYC_W'(1);

  logic [1:0]       state;
  logic [1:0]       cur_src;
  logic [1:0]       last_served;
  logic [1:0]       win_src;
  logic [CYC_W-1:0] cur_ncyc;
  logic [CYC_W-1:0] cnt;
  logic [CYC_W-1:0] win_ncyc;
  logic [2:0]       elig;
  logic             cur_elig;
  logic             start;
  logic             last_cyc;
  logic             in_arm;
  logic             in_send;

  assign elig               = src_req & src_fc_ok;
  assign have_trans_waiting = |elig;
  assign piorqq_req         = src_req[0];

  // Winner is only latched when some source is eligible, so the fallback value is don't-care.
  always_comb begin
    win_src = last_served;
`ifdef JBI_SCHED_RR_EN
    begin
      logic [1:0] cand;
      logic       found;
      found = 1'b0;
      cand  = (last_served == 2'd2) ? 2'd0 : last_served + 2'd1;
      for (int k = 0; k < 3; k++) begin
        if (!found && elig[cand]) begin
          win_src = cand;
          found   = 1'b1;
        end
        cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      end
    end
`else
    if (elig[2]) win_src = 2'd2;
    if (elig[0]) win_src = 2'd0;
    if (elig[1]) win_src = 2'd1;
`endif
  end

  always_comb begin
    case (win_src)
      2'd0:    win_ncyc = src_ncyc[0*CYC_W +: CYC_W];
      2'd1:    win_ncyc = src_ncyc[1*CYC_W +: CYC_W];
      default: win_ncyc = src_ncyc[2*CYC_W +: CYC_W];
    endcase
  end

  always_comb begin
    case (cur_src)
      2'd0:    cur_elig = elig[0];
      2'd1:    cur_elig = elig[1];
      default: cur_elig = elig[2];
    endcase
  end

  // Single-cycle packets need the grant itself; longer ones start on the arbiter's go-ahead.
  assign start    = (cur_ncyc == ONE) ? grant : multiple_ok;
  assign last_cyc = (cnt == cur_ncyc - ONE);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state       <= ST_IDLE;
      cur_src     <= 2'd0;
      cur_ncyc    <= '0;
      cnt         <= '0;
      last_served <= 2'd2;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|elig) begin
            state    <= ST_ARM;
            cur_src  <= win_src;
            cur_ncyc <= (win_ncyc == '0) ? ONE : win_ncyc;
          end
        end
        ST_ARM: begin
          if (start) begin
            state <= ST_SEND;
            cnt   <= '0;
          end else if (!cur_elig) begin
            state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (last_cyc) begin
            state       <= ST_IDLE;
            last_served <= cur_src;
            cnt         <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_arm  = (state == ST_ARM);
  assign in_send = (state == ST_SEND);

  assign int_req              = in_arm | in_send;
  assign drv_valid            = in_send;
  assign drv_src              = in_send ? cur_src : 2'd0;
  assign drv_cyc              = in_send ? cnt : '0;
  assign drv_last             = in_send & last_cyc;
  assign multiple_in_progress = in_send & ~last_cyc;
  assign stream_break_point   = in_arm | drv_last;
  assign src_pop              = drv_last ? (3'b001 << cur_src) : 3'b000;
  assign int_requestor_piorqq = (state != ST_IDLE) & (cur_src == 2'd0);

endmodule

// File: tb/tb_jbi_jbus_pkt_sched.sv
// Bench for jbi_jbus_pkt_sched: directed scenarios then random traffic, all checked
// every cycle against a packet-level reference model (honours JBI_SCHED_RR_EN).
module tb_jbi_jbus_pkt_sched;
  localparam int CYC_W = 4;

  logic               clk = 1'b0;
  logic               rst_l;
  logic [2:0]         src_req;
  logic [3*CYC_W-1:0] src_ncyc;
  logic [2:0]         src_fc_ok;
  logic               grant;
  logic               multiple_ok;
  logic               int_req;
  logic               multiple_in_progress;
  logic               stream_break_point;
  logic               have_trans_waiting;
  logic               piorqq_req;
  logic               int_requestor_piorqq;
  logic               drv_valid;
  logic [1:0]         drv_src;
  logic [CYC_W-1:0]   drv_cyc;
  logic               drv_last;
  logic [2:0]         src_pop;

  jbi_jbus_pkt_sched #(.CYC_W(CYC_W)) dut (
    .clk(clk), .rst_l(rst_l), .src_req(src_req), .src_ncyc(src_ncyc),
    .src_fc_ok(src_fc_ok), .grant(grant), .multiple_ok(multiple_ok),
    .int_req(int_req), .multiple_in_progress(multiple_in_progress),
    .stream_break_point(stream_break_point), .have_trans_waiting(have_trans_waiting),
    .piorqq_req(piorqq_req), .int_requestor_piorqq(int_requestor_piorqq),
    .drv_valid(drv_valid), .drv_src(drv_src), .drv_cyc(drv_cyc),
    .drv_last(drv_last), .src_pop(src_pop)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: a packet is either waiting for the bus or has m_left cycles still to drive
  bit m_armed;
  int m_left;
  int m_src;
  int m_len;
  int m_ls;

  bit         rec_pops;
  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] el);
    int w;
    w = -1;
`ifdef JBI_SCHED_RR_EN
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_ls + k) % 3;
      if (w < 0 && el[c]) w = c;
    end
`else
    if (el[2]) w = 2;
    if (el[0]) w = 0;
    if (el[1]) w = 1;
`endif
    return w;
  endfunction

  function automatic void model_reset();
    m_armed = 1'b0;
    m_left  = 0;
    m_src   = 0;
    m_len   = 1;
    m_ls    = 2;
  endfunction

  // driver
  task automatic set_in(input logic [2:0] req, input logic [3*CYC_W-1:0] ncyc,
                        input logic [2:0] fc, input logic gnt, input logic mok);
    src_req     = req;
    src_ncyc    = ncyc;
    src_fc_ok   = fc;
    grant       = gnt;
    multiple_ok = mok;
  endtask

  // check current outputs against the model, then clock both
  task automatic step();
    logic [2:0] el;
    logic       e_ireq, e_dv, e_last, e_mip, e_sbp, e_pio;
    logic [1:0] e_src;
    logic [3:0] e_cyc;
    logic [2:0] e_pop;
    bit         go;
    int         w;
    #2;
    el     = src_req & src_fc_ok;
    e_ireq = 1'b0; e_dv = 1'b0; e_last = 1'b0; e_mip = 1'b0; e_sbp = 1'b0;
    e_src  = 2'd0; e_cyc = 4'd0; e_pop = 3'b000;
    if (m_left > 0) begin
      e_ireq = 1'b1;
      e_dv   = 1'b1;
      e_src  = 2'(m_src);
      e_cyc  = 4'(m_len - m_left);
      e_last = (m_left == 1);
      e_mip  = !e_last;
      e_sbp  = e_last;
      e_pop  = e_last ? 3'(1 << m_src) : 3'b000;
    end else if (m_armed) begin
      e_ireq = 1'b1;
      e_sbp  = 1'b1;
    end
    e_pio = (m_armed || m_left > 0) && (m_src == 0);
    chk("int_req", 32'(int_req), 32'(e_ireq));
    chk("multiple_in_progress", 32'(multiple_in_progress), 32'(e_mip));
    chk("stream_break_point", 32'(stream_break_point), 32'(e_sbp));
    chk("have_trans_waiting", 32'(have_trans_waiting), 32'(|el));
    chk("piorqq_req", 32'(piorqq_req), 32'(src_req[0]));
    chk("int_requestor_piorqq", 32'(int_requestor_piorqq), 32'(e_pio));
    chk("drv_valid", 32'(drv_valid), 32'(e_dv));
    chk("drv_src", 32'(drv_src), 32'(e_src));
    chk("drv_cyc", 32'(drv_cyc), 32'(e_cyc));
    chk("drv_last", 32'(drv_last), 32'(e_last));
    chk("src_pop", 32'(src_pop), 32'(e_pop));
    if (rec_pops && src_pop != 3'b000)
      got_q.push_back(src_pop == 3'b001 ? 2'd0 : (src_pop == 3'b010 ? 2'd1 : 2'd2));
    @(posedge clk);
    if (!rst_l) begin
      model_reset();
    end else if (m_left > 0) begin
      if (m_left == 1) m_ls = m_src;
      m_left--;
    end else if (m_armed) begin
      go = (m_len == 1) ? grant : multiple_ok;
      if (go) begin
        m_left  = m_len;
        m_armed = 1'b0;
      end else if (!el[m_src]) begin
        m_armed = 1'b0;
      end
    end else begin
      w = pick(el);
      if (w >= 0) begin
        m_armed = 1'b1;
        m_src   = w;
        m_len   = int'(src_ncyc[w*CYC_W +: CYC_W]);
        if (m_len == 0) m_len = 1;
      end
    end
    #1;
  endtask

  initial begin
    model_reset();
    rec_pops = 1'b0;
    rst_l    = 1'b0;
    set_in(3'b000, '0, 3'b111, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_int_req", 32'(int_req), 32'd0);
    chk("rst_drv_valid", 32'(drv_valid), 32'd0);
    chk("rst_src_pop", 32'(src_pop), 32'd0);
    step();
    rst_l = 1'b1;
    step();

    // single-cycle PIO packet with grant held
    set_in(3'b001, 12'h001, 3'b111, 1'b1, 1'b0);
    repeat (3) step();

    // all sources busy with 1-cycle packets; PIO was served last
    set_in(3'b111, 12'h111, 3'b111, 1'b1, 1'b0);
`ifdef JBI_SCHED_RR_EN
    exp_q = '{2'd1, 2'd2, 2'd0, 2'd1};
`else
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd1};
`endif
    rec_pops = 1'b1;
    repeat (12) step();
    rec_pops = 1'b0;
    chk("prio_count", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      logic [31:0] o;
      o = (i < got_q.size()) ? 32'(got_q[i]) : 32'hffff;
      chk("prio_order", o, 32'(exp_q[i]));
    end
    set_in(3'b000, '0, 3'b111, 1'b0, 1'b0);
    repeat (2) step();

    // 9-cycle DMA return, go-ahead after two waiting cycles
    set_in(3'b010, 12'h090, 3'b111, 1'b0, 1'b0);
    repeat (3) step();
    multiple_ok = 1'b1;
    step();
    multiple_ok = 1'b0;
    repeat (9) step();
    src_req = 3'b000;
    repeat (2) step();

    // int-ack aborted by flow control while waiting for grant
    set_in(3'b100, 12'h100, 3'b111, 1'b0, 1'b0);
    repeat (2) step();
    src_fc_ok = 3'b011;
    step();
    chk("abort_int_req", 32'(int_req), 32'd0);
    step();

    // flow control drops in the same cycle the grant arrives: packet still goes
    set_in(3'b100, 12'h100, 3'b111, 1'b1, 1'b0);
    step();
    src_fc_ok = 3'b011;
    step();
    chk("abort_start_pop", 32'(src_pop), 32'h4);
    step();
    src_req = 3'b000;
    step();

    // reset in the middle of a 9-cycle packet
    set_in(3'b010, 12'h090, 3'b111, 1'b0, 1'b1);
    repeat (6) step();
    chk("rst_mid_cyc", 32'(drv_cyc), 32'd4);
    rst_l = 1'b0;
    step();
    rst_l = 1'b1;
    src_req = 3'b000;
    chk("rst_mid_valid", 32'(drv_valid), 32'd0);
    chk("rst_mid_pop", 32'(src_pop), 32'd0);
    chk("rst_mid_req", 32'(int_req), 32'd0);
    repeat (2) step();

    // random traffic
    repeat (600) begin
      logic [2:0] fc;
      for (int b = 0; b < 3; b++) fc[b] = ($urandom_range(0, 3) != 0);
      set_in(3'($urandom_range(0, 7)), 12'($urandom), fc,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rst_l = ($urandom_range(0, 79) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
